// File: rtl/fp_unit_arbiter.sv
// Round-robin scheduler sharing one pipelined fixed-latency FPU among NUM_REQ requesters.
// Define FP_NAN_CANON_EN to canonicalise NaN results to 32'h7FC0_0000 and raise rsp_nan.
module fp_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FPU_LAT = 3,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*2-1:0]   req_op,
  output logic                   fpu_vld,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_op,
  input  logic [31:0]            fpu_res,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic [31:0]            rsp_res,
  output logic                   rsp_nan
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      out_cnt_q [NUM_REQ];
  logic [CW-1:0]      out_cnt_d [NUM_REQ];
  logic               fpu_vld_q, fpu_vld_d;
  logic [31:0]        fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [1:0]         fpu_op_q, fpu_op_d;
  logic [IDW-1:0]     issue_id_q, issue_id_d;
  logic [FPU_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]     tag_id_q [FPU_LAT];
  logic [IDW-1:0]     tag_id_d [FPU_LAT];
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [31:0]        rsp_res_q, rsp_res_d;
  logic               rsp_nan_q, rsp_nan_d;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_idx;
  logic [31:0]        sel_a, sel_b;
  logic [1:0]         sel_op;
  logic [31:0]        canon_res;
  logic               canon_nan;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && (out_cnt_q[i] < CW'(MAX_OUT));
    end
  end

  // Scan upward from the RR pointer with wrap-around; first eligible wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    req_rdy   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
    if (grant_vld) req_rdy[grant_id] = 1'b1;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[2*i +: 2];
      end
    end
  end

  // Issue stage: operands hold when idle; reserved opcode issues as add.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    fpu_vld_d  = grant_vld;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    fpu_op_d   = fpu_op_q;
    issue_id_d = issue_id_q;
    if (grant_vld) begin
      rr_ptr_d   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : IDW'(grant_id + 1'b1);
      fpu_a_d    = sel_a;
      fpu_b_d    = sel_b;
      fpu_op_d   = (sel_op == 2'b11) ? 2'b00 : sel_op;
      issue_id_d = grant_id;
    end
  end

  // Tag pipeline: head entry lines up with fpu_res of the same operation.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = fpu_vld_q;
    tag_id_d[0]  = issue_id_q;
    for (int unsigned k = 1; k < FPU_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

`ifdef FP_NAN_CANON_EN
  logic res_is_nan;
  assign res_is_nan = (fpu_res[30:23] == 8'hFF) && (fpu_res[22:0] != 23'd0);
  assign canon_res  = res_is_nan ? 32'h7FC0_0000 : fpu_res;
  assign canon_nan  = res_is_nan;
`else
  assign canon_res  = fpu_res;
  assign canon_nan  = 1'b0;
`endif

  always_comb begin
    rsp_vld_d = '0;
    rsp_res_d = rsp_res_q;
    rsp_nan_d = 1'b0;
    if (tag_vld_q[FPU_LAT-1]) begin
      rsp_vld_d[tag_id_q[FPU_LAT-1]] = 1'b1;
      rsp_res_d = canon_res;
      rsp_nan_d = canon_nan;
    end
  end

  // Outstanding count: +1 on transfer, -1 on response pulse, both cancel.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (grant_vld && (grant_id == IDW'(i)) && !rsp_vld_q[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + CW'(1);
      end else if (rsp_vld_q[i] && !(grant_vld && (grant_id == IDW'(i)))) begin
        out_cnt_d[i] = out_cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      fpu_vld_q  <= 1'b0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= '0;
      issue_id_q <= '0;
      tag_vld_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_res_q  <= '0;
      rsp_nan_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
      for (int k = 0; k < FPU_LAT; k++) tag_id_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fpu_vld_q  <= fpu_vld_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      issue_id_q <= issue_id_d;
      tag_vld_q  <= tag_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_res_q  <= rsp_res_d;
      rsp_nan_q  <= rsp_nan_d;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
      for (int k = 0; k < FPU_LAT; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end

  assign fpu_vld = fpu_vld_q;
  assign fpu_a   = fpu_a_q;
  assign fpu_b   = fpu_b_q;
  assign fpu_op  = fpu_op_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_res = rsp_res_q;
  assign rsp_nan = rsp_nan_q;

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_chk
    cnt_max_a: assert property (@(posedge clk) disable iff (rst)
      out_cnt_q[gi] <= CW'(MAX_OUT));
    cnt_min_a: assert property (@(posedge clk) disable iff (rst)
      !(rsp_vld_q[gi] && (out_cnt_q[gi] == '0)));
  end
`endif

endmodule
